// File: rtl/gb_length_bank.sv
// Bank of independent Game Boy style length counters with the
// frame-sequencer extra-clock quirks on length-enable and trigger.
module gb_length_bank #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 6,
    parameter int EXTRA_CLK = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_length_ctr,
    input  logic                          len_phase,
    input  logic [NUM_CH-1:0]             length_wr,
    input  logic [WIDTH-1:0]              length_data,
    input  logic [NUM_CH-1:0]             trigger,
    input  logic [NUM_CH-1:0]             single,
    input  logic [NUM_CH-1:0]             dac_off,
    output logic [NUM_CH-1:0]             enable,
    output logic [NUM_CH*(WIDTH+1)-1:0]   length_left,
    output logic [NUM_CH-1:0]             expire
);

    localparam logic [WIDTH:0] FULL    = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] FULL_M1 = FULL - {{WIDTH{1'b0}}, 1'b1};
    localparam logic           QUIRKS  = (EXTRA_CLK != 0);

    logic [NUM_CH-1:0][WIDTH:0] rem_q, rem_d, rem_a, rem_b;
    logic [NUM_CH-1:0]          enable_q, enable_d;
    logic [NUM_CH-1:0]          expire_q, expire_d;
    logic [NUM_CH-1:0]          single_q, single_d;
    logic [NUM_CH-1:0]          extra, tick_dec, reached_zero;

    // Per channel: register write first, then the extra clock, then either
    // the trigger reload or the regular length tick.
    always_comb begin
        rem_a        = rem_q;
        rem_b        = rem_q;
        rem_d        = rem_q;
        enable_d     = enable_q;
        expire_d     = '0;
        single_d     = single;
        extra        = '0;
        tick_dec     = '0;
        reached_zero = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (length_wr[i]) begin
                rem_a[i] = FULL - {1'b0, length_data};
            end
            extra[i] = QUIRKS && single[i] && !single_q[i] && len_phase &&
                       !length_wr[i] && (rem_a[i] != '0);
            rem_b[i] = rem_a[i] - {{WIDTH{1'b0}}, extra[i]};
            tick_dec[i] = clk_length_ctr && single[i] && !trigger[i] &&
                          !length_wr[i] && (rem_b[i] != '0);
            if (trigger[i]) begin
                if (rem_b[i] == '0) begin
                    rem_d[i] = (QUIRKS && single[i] && len_phase) ? FULL_M1 : FULL;
                end else begin
                    rem_d[i] = rem_b[i];
                end
                enable_d[i] = !dac_off[i];
            end else begin
                rem_d[i] = rem_b[i] - {{WIDTH{1'b0}}, tick_dec[i]};
                reached_zero[i] = (extra[i] || tick_dec[i]) && (rem_d[i] == '0);
                if (dac_off[i] || reached_zero[i]) begin
                    enable_d[i] = 1'b0;
                end
                // Only a live channel announces its own expiry.
                expire_d[i] = reached_zero[i] && enable_q[i] && !dac_off[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q    <= '0;
            enable_q <= '0;
            expire_q <= '0;
            single_q <= '0;
        end else begin
            rem_q    <= rem_d;
            enable_q <= enable_d;
            expire_q <= expire_d;
            single_q <= single_d;
        end
    end

    assign enable      = enable_q;
    assign expire      = expire_q;
    assign length_left = rem_q;

endmodule

// File: tb/tb_gb_length_bank.sv
// Directed self-checking bench for gb_length_bank (NUM_CH=4, WIDTH=6).
module tb_gb_length_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_length_ctr;
    logic        len_phase;
    logic [3:0]  length_wr;
    logic [5:0]  length_data;
    logic [3:0]  trigger;
    logic [3:0]  single;
    logic [3:0]  dac_off;
    logic [3:0]  enable;
    logic [27:0] length_left;
    logic [3:0]  expire;

    int vectors = 0;
    int miscompares = 0;

    gb_length_bank #(.NUM_CH(4), .WIDTH(6), .EXTRA_CLK(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_length_ctr (clk_length_ctr),
        .len_phase      (len_phase),
        .length_wr      (length_wr),
        .length_data    (length_data),
        .trigger        (trigger),
        .single         (single),
        .dac_off        (dac_off),
        .enable         (enable),
        .length_left    (length_left),
        .expire         (expire)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] rem_of(input int ch);
        return length_left[ch*7 +: 7];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        clk_length_ctr = 1'b0;
        len_phase      = 1'b0;
        length_wr      = '0;
        length_data    = '0;
        trigger        = '0;
        single         = '0;
        dac_off        = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        vectors++;
        if (enable !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_enable got %h want %h", enable, 4'h0);
        end
        vectors++;
        if (length_left !== 28'h0) begin
            miscompares++;
            $display("FAIL reset_length_left got %h want %h", length_left, 28'h0);
        end
        vectors++;
        if (expire !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_expire got %h want %h", expire, 4'h0);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_count();
        logic [6:0] want [4] = '{7'd3, 7'd2, 7'd1, 7'd0};
        apply_reset();
        single[0] = 1'b1;
        length_wr[0] = 1'b1;
        length_data = 6'd60;
        step();
        length_wr = '0;
        vectors++;
        if (rem_of(0) !== 7'd4) begin
            miscompares++;
            $display("FAIL count_load got %0d want %0d", rem_of(0), 4);
        end
        trigger[0] = 1'b1;
        step();
        trigger = '0;
        vectors++;
        if (enable[0] !== 1'b1 || rem_of(0) !== 7'd4) begin
            miscompares++;
            $display("FAIL count_trigger got en=%b rem=%0d want en=1 rem=4", enable[0], rem_of(0));
        end
        for (int t = 0; t < 4; t++) begin
            clk_length_ctr = 1'b1;
            step();
            clk_length_ctr = 1'b0;
            vectors++;
            if (rem_of(0) !== want[t] || enable[0] !== (t != 3) || expire[0] !== (t == 3)) begin
                miscompares++;
                $display("FAIL count_tick%0d got rem=%0d en=%b exp=%b want rem=%0d en=%b exp=%b",
                         t, rem_of(0), enable[0], expire[0], want[t], (t != 3), (t == 3));
            end
        end
        clk_length_ctr = 1'b1;
        step();
        clk_length_ctr = 1'b0;
        vectors++;
        if (rem_of(0) !== 7'd0 || expire[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL count_floor got rem=%0d exp=%b want rem=0 exp=0", rem_of(0), expire[0]);
        end
    endtask

    task automatic test_trigger_reload();
        apply_reset();
        single[1] = 1'b1;
        len_phase = 1'b1;
        step();
        trigger[1] = 1'b1;
        step();
        trigger = '0;
        len_phase = 1'b0;
        vectors++;
        if (rem_of(1) !== 7'd63 || enable[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL reload_phase1 got rem=%0d en=%b want rem=63 en=1", rem_of(1), enable[1]);
        end
        apply_reset();
        single[1] = 1'b1;
        step();
        trigger[1] = 1'b1;
        step();
        trigger = '0;
        vectors++;
        if (rem_of(1) !== 7'd64 || enable[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL reload_phase0 got rem=%0d en=%b want rem=64 en=1", rem_of(1), enable[1]);
        end
    endtask

    task automatic test_extra_clock();
        apply_reset();
        length_wr[2] = 1'b1;
        length_data = 6'd59;
        step();
        length_wr = '0;
        trigger[2] = 1'b1;
        step();
        trigger = '0;
        vectors++;
        if (rem_of(2) !== 7'd5 || enable[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL extra_setup got rem=%0d en=%b want rem=5 en=1", rem_of(2), enable[2]);
        end
        single[2] = 1'b1;
        len_phase = 1'b1;
        step();
        len_phase = 1'b0;
        vectors++;
        if (rem_of(2) !== 7'd4) begin
            miscompares++;
            $display("FAIL extra_dec got %0d want %0d", rem_of(2), 4);
        end
        single[2] = 1'b0;
        step();
        length_wr[2] = 1'b1;
        length_data = 6'd63;
        step();
        length_wr = '0;
        single[2] = 1'b1;
        len_phase = 1'b1;
        step();
        len_phase = 1'b0;
        vectors++;
        if (rem_of(2) !== 7'd0 || enable[2] !== 1'b0 || expire[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL extra_expire got rem=%0d en=%b exp=%b want rem=0 en=0 exp=1",
                     rem_of(2), enable[2], expire[2]);
        end
        step();
        vectors++;
        if (expire[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL extra_pulse_width got %b want %b", expire[2], 1'b0);
        end
    endtask

    task automatic test_trigger_vs_tick();
        apply_reset();
        single[3] = 1'b1;
        step();
        length_wr[3] = 1'b1;
        length_data = 6'd54;
        step();
        length_wr = '0;
        trigger[3] = 1'b1;
        clk_length_ctr = 1'b1;
        step();
        trigger = '0;
        clk_length_ctr = 1'b0;
        vectors++;
        if (rem_of(3) !== 7'd10 || enable[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL trig_tick got rem=%0d en=%b want rem=10 en=1", rem_of(3), enable[3]);
        end
        length_wr[3] = 1'b1;
        length_data = 6'd50;
        clk_length_ctr = 1'b1;
        step();
        length_wr = '0;
        clk_length_ctr = 1'b0;
        vectors++;
        if (rem_of(3) !== 7'd14) begin
            miscompares++;
            $display("FAIL wr_tick got %0d want %0d", rem_of(3), 14);
        end
        clk_length_ctr = 1'b1;
        step();
        clk_length_ctr = 1'b0;
        vectors++;
        if (rem_of(3) !== 7'd13) begin
            miscompares++;
            $display("FAIL plain_tick got %0d want %0d", rem_of(3), 13);
        end
        length_wr[3] = 1'b1;
        length_data = 6'd0;
        trigger[3] = 1'b1;
        step();
        length_wr = '0;
        trigger = '0;
        vectors++;
        if (rem_of(3) !== 7'd64 || enable[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL wr0_trig got rem=%0d en=%b want rem=64 en=1", rem_of(3), enable[3]);
        end
    endtask

    task automatic test_dac_off();
        apply_reset();
        single[0] = 1'b1;
        length_wr[0] = 1'b1;
        length_data = 6'd54;
        step();
        length_wr = '0;
        trigger[0] = 1'b1;
        step();
        trigger = '0;
        dac_off[0] = 1'b1;
        step();
        vectors++;
        if (enable[0] !== 1'b0 || rem_of(0) !== 7'd10) begin
            miscompares++;
            $display("FAIL dac_disable got en=%b rem=%0d want en=0 rem=10", enable[0], rem_of(0));
        end
        clk_length_ctr = 1'b1;
        step();
        clk_length_ctr = 1'b0;
        vectors++;
        if (rem_of(0) !== 7'd9 || expire[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL dac_count got rem=%0d exp=%b want rem=9 exp=0", rem_of(0), expire[0]);
        end
        trigger[0] = 1'b1;
        step();
        trigger = '0;
        vectors++;
        if (enable[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL dac_trigger got %b want %b", enable[0], 1'b0);
        end
        length_wr[0] = 1'b1;
        length_data = 6'd63;
        step();
        length_wr = '0;
        clk_length_ctr = 1'b1;
        step();
        clk_length_ctr = 1'b0;
        vectors++;
        if (rem_of(0) !== 7'd0 || expire[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL dac_silent_expiry got rem=%0d exp=%b want rem=0 exp=0", rem_of(0), expire[0]);
        end
        dac_off[0] = 1'b0;
        trigger[0] = 1'b1;
        step();
        trigger = '0;
        vectors++;
        if (enable[0] !== 1'b1 || rem_of(0) !== 7'd64) begin
            miscompares++;
            $display("FAIL dac_reenable got en=%b rem=%0d want en=1 rem=64", enable[0], rem_of(0));
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        single = 4'hF;
        step();
        trigger = 4'hF;
        step();
        trigger = '0;
        clk_length_ctr = 1'b1;
        step();
        clk_length_ctr = 1'b0;
        vectors++;
        if (enable !== 4'hF || length_left !== {4{7'd63}}) begin
            miscompares++;
            $display("FAIL mid_setup got en=%h left=%h want en=f left=%h", enable, length_left, {4{7'd63}});
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (enable !== 4'h0 || length_left !== 28'h0 || expire !== 4'h0) begin
            miscompares++;
            $display("FAIL mid_async got en=%h left=%h exp=%h want all zero", enable, length_left, expire);
        end
        single = '0;
        step();
        reset = 1'b1;
        step();
        trigger[0] = 1'b1;
        step();
        trigger = '0;
        vectors++;
        if (rem_of(0) !== 7'd64 || enable[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_trig got rem=%0d en=%b want rem=64 en=1", rem_of(0), enable[0]);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_trigger_reload();
        test_extra_clock();
        test_trigger_vs_tick();
        test_dac_off();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gb_length_bank.md
GB_LENGTH_BANK -- requirements
Module: gb_length_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent length channels.
REQ-002 SHALL have parameter WIDTH, default 6: length field width; max count 2^WIDTH (6 for ch1/2/4, 8 for ch3).
REQ-003 SHALL have parameter EXTRA_CLK, default 1: 1 enables frame-sequencer extra-clock quirks (REQ-019..021).
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 clk_length_ctr  in  1  one-cycle length-tick strobe from frame sequencer.
REQ-007 len_phase  in  1  high while the next frame-sequencer step will not clock length.
REQ-008 length_wr  in  NUM_CH  per-channel length-register write strobe.
REQ-009 length_data  in  WIDTH  shared length value for length_wr.
REQ-010 trigger  in  NUM_CH  per-channel start strobe.
REQ-011 single  in  NUM_CH  per-channel length-enable level.
REQ-012 dac_off  in  NUM_CH  per-channel DAC-disabled level; forces channel off.
REQ-013 enable  out  NUM_CH  channel active.
REQ-014 length_left  out  NUM_CH*(WIDTH+1)  remaining count, channel i at bits [i*(WIDTH+1) +: WIDTH+1].
REQ-015 expire  out  NUM_CH  one-cycle pulse when length expiry disables a channel.

Function
REQ-016 Per channel: down-counter rem, WIDTH+1 bits, range 0..2^WIDTH; channels fully independent.
REQ-017 length_wr[i]: rem <= 2^WIDTH - length_data (1..2^WIDTH), any time, enable unchanged.
REQ-018 clk_length_ctr with single[i]=1 and rem!=0: rem decrements; on reaching 0 enable[i] <= 0 and expire[i] pulses next cycle; rem=0 or single=0: no change.
REQ-019 EXTRA_CLK=1, single[i] 0->1 (vs registered previous value) while len_phase=1 and rem!=0: one extra decrement; reaching 0 applies REQ-018 expiry unless trigger[i] same cycle.
REQ-020 trigger[i]: enable[i] <= !dac_off[i]; if rem==0, rem <= 2^WIDTH; rem!=0 untouched.
REQ-021 EXTRA_CLK=1, trigger[i] reloading to 2^WIDTH with single[i]=1 and len_phase=1: rem <= 2^WIDTH-1 instead.
REQ-022 Same-cycle priority per channel: length_wr applied first, trigger evaluates updated rem; trigger suppresses clk_length_ctr decrement that cycle; length_wr suppresses decrement that cycle.
REQ-023 dac_off[i]=1: enable[i] <= 0 next cycle, rem unaffected, no expire pulse; remains off until trigger with dac_off=0.
REQ-024 Disabled channel (enable=0) still decrements rem per REQ-018 but never pulses expire.
REQ-025 Latency: all outputs registered, one cycle after causing input; no combinational input-to-output path.
REQ-026 rem SHALL never wrap below 0 or exceed 2^WIDTH.

Reset
REQ-027 reset low asynchronously forces enable=0, every rem=0, expire=0, registered single=0.
REQ-028 reset deassertion synchronous to clk; first state change on first rising edge after release.
REQ-029 reset mid-count discards all channel state; post-reset trigger reloads 2^WIDTH.

Verification (WIDTH=6, NUM_CH=4)
REQ-030 length_wr[0] data=60, trigger[0], single[0]=1, len_phase=0, 4 ticks -> rem 4,3,2,1,0; enable[0] falls with tick 4; expire[0] one pulse.
REQ-031 trigger[1] after reset, single=1, len_phase=1 -> rem[1]=63; same with len_phase=0 -> 64.
REQ-032 rem[2]=5, single[2] 0->1 with len_phase=1 -> rem 4 next cycle; rem=1 case -> enable 0, expire pulse.
REQ-033 trigger[3] and clk_length_ctr same cycle, rem=10, single=1 -> rem stays 10, enable=1; length_wr data=0 plus trigger same cycle -> rem=64.
REQ-034 dac_off[0]=1 while counting -> enable[0]=0, rem continues, no expire; trigger with dac_off=1 -> enable stays 0.
REQ-035 reset low mid-count on all channels -> immediately enable=0, length_left=0, expire=0.
